// File: rtl/pdm_pkg.sv
// Shared PDM helpers: clock divisor, accumulator sizing, full-scale constant and saturation.
package pdm_pkg;

  function automatic int unsigned half_div(input int unsigned in_freq, input int unsigned out_freq);
    int unsigned d;
    d = in_freq / (2 * out_freq);
    return (d < 1) ? 1 : d;
  endfunction

  function automatic int unsigned acc_width(input int unsigned pcm_width);
    return pcm_width + 3;
  endfunction

  function automatic logic signed [63:0] full_scale(input int unsigned pcm_width);
    return 64'sd1 <<< (pcm_width - 1);
  endfunction

  // Clamp v into the signed range of a width-bit register.
  function automatic logic signed [63:0] sat(input logic signed [63:0] v, input int unsigned width);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (width - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (width - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/pdm_tx_clk_gen.sv
// PDM bit clock divider; fall_tick marks the cycle in which pdm_clk is registered 1->0.
module pdm_tx_clk_gen
  import pdm_pkg::*;
#(
  parameter int unsigned INPUT_FREQ  = 50_000_000,
  parameter int unsigned OUTPUT_FREQ = 2_400_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic pdm_clk,
  output logic fall_tick
);

  localparam int unsigned HALF  = half_div(INPUT_FREQ, OUTPUT_FREQ);
  localparam int unsigned DIV_W = $clog2(HALF + 1);
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(HALF - 1);

  logic [DIV_W-1:0] div;
  logic             wrap;

  assign wrap      = en && (div == DIV_MAX);
  assign fall_tick = wrap && pdm_clk;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div     <= '0;
      pdm_clk <= 1'b0;
    end else if (!en) begin
      div     <= '0;
      pdm_clk <= 1'b0;
    end else if (wrap) begin
      div     <= '0;
      pdm_clk <= ~pdm_clk;
    end else begin
      div <= div + DIV_W'(1);
    end
  end

endmodule

// File: rtl/pdm_speaker_tx.sv
// PCM-to-PDM playback path: one-entry sample buffer, OSR bit counter and 2nd-order sigma-delta.
module pdm_speaker_tx
  import pdm_pkg::*;
#(
  parameter int unsigned INPUT_FREQ = 50_000_000,
  parameter int unsigned PDM_FREQ   = 2_400_000,
  parameter int unsigned PCM_WIDTH  = 16,
  parameter int unsigned OSR        = 50
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        en,
  input  logic signed [PCM_WIDTH-1:0] pcm_data,
  input  logic                        pcm_valid,
  output logic                        pcm_ready,
  output logic                        underrun,
  output logic                        pdm_clk,
  output logic                        pdm_data
);

  localparam int unsigned ACC_W = acc_width(PCM_WIDTH);
  localparam int unsigned CNT_W = $clog2(OSR);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(OSR - 1);
  localparam logic signed [63:0] FS = full_scale(PCM_WIDTH);

  logic                        fall_tick;
  logic                        buf_full;
  logic                        xfer;
  logic                        boundary;
  logic signed [PCM_WIDTH-1:0] buf_data;
  logic signed [PCM_WIDTH-1:0] cur_sample;
  logic [CNT_W-1:0]            cnt;
  logic signed [ACC_W-1:0]     i1;
  logic signed [ACC_W-1:0]     i2;
  logic signed [ACC_W-1:0]     i1n;
  logic signed [ACC_W-1:0]     i2n;
  logic signed [63:0]          x_ext;
  logic signed [63:0]          fb;

  pdm_tx_clk_gen #(
    .INPUT_FREQ  (INPUT_FREQ),
    .OUTPUT_FREQ (PDM_FREQ)
  ) u_clk_gen (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .pdm_clk   (pdm_clk),
    .fall_tick (fall_tick)
  );

  assign pcm_ready = en & ~buf_full;
  assign xfer      = pcm_valid & pcm_ready;
  assign boundary  = fall_tick && (cnt == '0);

  // Modulator step uses the pre-load sample; a freshly loaded sample acts from the next tick.
  always_comb begin
    x_ext = 64'(cur_sample);
    fb    = pdm_data ? FS : -FS;
    i1n   = ACC_W'(sat(64'(i1) + x_ext - fb, ACC_W));
    i2n   = ACC_W'(sat(64'(i2) + 64'(i1n) - fb, ACC_W));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_full   <= 1'b0;
      buf_data   <= '0;
      cur_sample <= '0;
      cnt        <= '0;
      i1         <= '0;
      i2         <= '0;
      pdm_data   <= 1'b0;
      underrun   <= 1'b0;
    end else if (!en) begin
      buf_full   <= 1'b0;
      buf_data   <= '0;
      cur_sample <= '0;
      cnt        <= '0;
      i1         <= '0;
      i2         <= '0;
      pdm_data   <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      underrun <= 1'b0;
      // Sample boundary: buffered sample, same-cycle bypass, or silence with an underrun flag.
      if (boundary) begin
        if (buf_full) begin
          cur_sample <= buf_data;
          buf_full   <= 1'b0;
        end else if (xfer) begin
          cur_sample <= pcm_data;
        end else begin
          cur_sample <= '0;
          underrun   <= 1'b1;
        end
      end else if (xfer) begin
        buf_data <= pcm_data;
        buf_full <= 1'b1;
      end
      if (fall_tick) begin
        cnt      <= (cnt == CNT_MAX) ? '0 : cnt + CNT_W'(1);
        i1       <= i1n;
        i2       <= i2n;
        pdm_data <= ~i2n[ACC_W-1];
      end
    end
  end

endmodule
